// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 SEQ control path: icodes, status codes,
// sequencer states and the memory-stage icode classifier.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h0;
  localparam logic [3:0] I_HALT   = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PC_UPDATE, S_STOP
  } state_e;

  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Single shared memory port between the sequencer and the memory system.
interface y86_seq_ctrl_if;
  logic mem_req_o;
  logic mem_is_data_o;
  logic mem_ack_i;
  logic mem_err_i;

  modport master (output mem_req_o, mem_is_data_o, input mem_ack_i, mem_err_i);
  modport slave  (input mem_req_o, mem_is_data_o, output mem_ack_i, mem_err_i);
endinterface

// File: rtl/y86_mem_timer.sv
// Wait counter for an outstanding memory request; expired flags the last
// allowed request cycle passing without an ack.
module y86_mem_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) count <= '0;
    else if (en)      count <= count + 1'b1;
  end

  // en already excludes ack cycles, so a same-cycle ack never expires
  assign expired = en && (count == W'(LIMIT - 1));
endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle SEQ stage sequencer: one active stage at a time, shared memory
// port arbitration, CC gating and processor status.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  y86_seq_ctrl_if.master   mem,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             execute_en_o,
  output logic             memory_en_o,
  output logic             writeback_en_o,
  output logic             pc_en_o,
  output logic             cc_en_o,
  output logic [2:0]       stat_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state, state_n;
  logic [3:0]       icode_q, icode_n;
  logic [2:0]       stat_q, stat_n;
  logic [CNT_W-1:0] retired_q, retired_n;
  logic             expired;
  logic             in_mem_wait;

  assign in_mem_wait = (state == S_FETCH) || (state == S_MEMORY);

  y86_mem_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (!in_mem_wait),
    .en      (in_mem_wait && !mem.mem_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      icode_q   <= '0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      state     <= state_n;
      icode_q   <= icode_n;
      stat_q    <= stat_n;
      retired_q <= retired_n;
    end
  end

  always_comb begin
    state_n   = state;
    icode_n   = icode_q;
    stat_n    = stat_q;
    retired_n = retired_q;
    case (state)
      S_IDLE: if (start_i) state_n = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ack_i) begin
          if (mem.mem_err_i) begin
            state_n = S_STOP;
            stat_n  = STAT_ADR;
          end else if (!instr_valid_i) begin
            state_n = S_STOP;
            stat_n  = STAT_INS;
          end else if (icode_i == I_HALT) begin
            state_n   = S_STOP;
            stat_n    = STAT_HLT;
            retired_n = retired_q + 1'b1;
          end else begin
            icode_n = icode_i;
            state_n = S_DECODE;
          end
        end else if (expired) begin
          state_n = S_STOP;
          stat_n  = STAT_ADR;
        end
      end
      S_DECODE:  state_n = S_EXECUTE;
      S_EXECUTE: state_n = is_mem_icode(icode_q) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (mem.mem_ack_i) begin
          if (mem.mem_err_i) begin
            state_n = S_STOP;
            stat_n  = STAT_ADR;
          end else begin
            state_n = S_WRITEBACK;
          end
        end else if (expired) begin
          state_n = S_STOP;
          stat_n  = STAT_ADR;
        end
      end
      S_WRITEBACK: state_n = S_PC_UPDATE;
      S_PC_UPDATE: begin
        retired_n = retired_q + 1'b1;
        state_n   = S_FETCH;
      end
      S_STOP:  state_n = S_STOP;
      default: state_n = S_IDLE;
    endcase
  end

  assign fetch_en_o        = (state == S_FETCH);
  assign decode_en_o       = (state == S_DECODE);
  assign execute_en_o      = (state == S_EXECUTE);
  assign memory_en_o       = (state == S_MEMORY);
  assign writeback_en_o    = (state == S_WRITEBACK);
  assign pc_en_o           = (state == S_PC_UPDATE);
  assign cc_en_o           = (state == S_EXECUTE) && (icode_q == I_OPQ);
  assign mem.mem_req_o     = in_mem_wait;
  assign mem.mem_is_data_o = (state == S_MEMORY);
  assign stat_o            = stat_q;
  assign busy_o            = (state != S_IDLE) && (state != S_STOP);
  assign retired_o         = retired_q;

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
- Multi-cycle stage sequencer for the Y86-64 SEQ core. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC_UPDATE, one active stage at a time.
- Arbitrates the single shared memory port between instruction fetch and data access.
- Gates condition-code updates in the execute stage and reports processor status (Stat).

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for mem_ack_i before it is treated as an address error.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  leave IDLE and begin fetching.
- icode_i  in  4  icode from fetch logic; valid in the cycle mem_ack_i is high during FETCH.
- instr_valid_i  in  1  fetch decode says icode/ifun is legal; sampled with icode_i.
- mem_req_o  out  1  shared memory port request.
- mem_is_data_o  out  1  0 = instruction fetch, 1 = data access.
- mem_ack_i  in  1  memory completes the request this cycle.
- mem_err_i  in  1  memory error; qualified by mem_ack_i.
- fetch_en_o, decode_en_o, execute_en_o, memory_en_o, writeback_en_o, pc_en_o  out  1 each  stage enables, one-hot or all 0.
- cc_en_o  out  1  condition-code write enable for execute.
- stat_o  out  3  1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- busy_o  out  1  high in any state other than IDLE and STOP.
- retired_o  out  CNT_W  count of completed instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPDATE, STOP. Moore outputs decoded from the state register and the latched icode_q.
- Reset values: state = IDLE, all enables = 0, mem_req_o = 0, mem_is_data_o = 0, stat_o = 1, busy_o = 0, retired_o = 0, icode_q = 0, timer = 0.
- IDLE: waits for start_i; start_i = 1 moves to FETCH on the next edge.
- FETCH: fetch_en_o = 1, mem_req_o = 1, mem_is_data_o = 0. mem_req_o is held until ack and never withdrawn. On ack, resolve in this order:
  - mem_err_i = 1: go to STOP, stat = ADR.
  - instr_valid_i = 0: go to STOP, stat = INS.
  - icode_i = 1 (HALT): go to STOP, stat = HLT, retired += 1.
  - Otherwise: latch icode_q = icode_i and go to DECODE.
- DECODE: 1 cycle, then EXECUTE.
- EXECUTE: 1 cycle, execute_en_o = 1.
  - cc_en_o = 1 only when icode_q = 6 (OPQ).
  - Next state is MEMORY when icode_q is in {4, 5, 8, 9, A, B}; otherwise WRITEBACK.
- MEMORY: memory_en_o = 1, mem_req_o = 1, mem_is_data_o = 1, held until ack.
  - ack with mem_err_i = 1: go to STOP, stat = ADR, no writeback, PC not updated.
  - ack without error: go to WRITEBACK.
- WRITEBACK: 1 cycle, then PC_UPDATE.
- PC_UPDATE: 1 cycle, pc_en_o = 1, retired += 1, then FETCH.
- STOP: all enables 0 and stat_o frozen. Only rst_i exits STOP; start_i is ignored.
- Timeout:
  - The timer clears on entry to FETCH or MEMORY and increments each cycle without ack.
  - If the timer reaches MEM_TIMEOUT with no ack, go to STOP, stat = ADR, and drop mem_req_o next cycle.
  - An ack arriving in the same cycle the limit is reached wins.
- Ignored inputs: mem_ack_i and mem_err_i outside FETCH/MEMORY; start_i outside IDLE.
- Latency for a non-memory instruction with fetch ack after k request cycles: k + 4 cycles from FETCH entry back to FETCH. A memory instruction adds m, the number of MEMORY request cycles.
- Counter wrap: retired_o wraps modulo 2^CNT_W with no saturation.
- rst_i mid-operation: on the next edge all outputs take reset values, mem_req_o drops immediately, and an in-flight ack is discarded.

Decomposition:
- Package y86_pkg holds:
  - icode constants NOP..POPQ (0..B);
  - STAT_AOK/HLT/ADR/INS;
  - the state enum;
  - a function is_mem_icode(icode).
  Execute-side and fetch modules use the same constants.
- Sub-module y86_mem_timer: clear/enable inputs, expired output, width = clog2(MEM_TIMEOUT + 1).

Test Plan:
- Reset, start_i, fetch ack after 1 cycle, icode = 6 -> cc_en_o pulses once in EXECUTE, no MEMORY state, FETCH re-entered 5 cycles after first FETCH entry, retired_o = 1.
- icode = 5, fetch ack in 1, data ack after 3 cycles -> mem_is_data_o = 1 for 3 cycles, memory_en_o high 3 cycles, retired_o = 1, stat_o = 1.
- Fetch ack with icode = 1 -> STOP, stat_o = 2, retired_o = 1, busy_o = 0; a later start_i has no effect.
- Fetch ack with instr_valid_i = 0 -> stat_o = 4. Data ack with mem_err_i = 1 for icode = A -> stat_o = 3, pc_en_o never asserted, retired_o unchanged.
- No ack for 15 cycles in MEMORY -> stat_o = 3. Repeat with ack on exactly the 15th cycle -> completes normally, stat_o = 1.
- Assert rst_i during MEMORY with mem_req_o = 1 -> next edge: mem_req_o = 0, state IDLE, retired_o = 0, stat_o = 1.
